uart_rx: RTL and testbench

UART receive path for the Wishbone UART. It deserializes an asynchronous 8N1 serial line using 16x oversampling and takes each sample at mid-bit. Received bytes go into a small first-word-fall-through FIFO, which the bus-side logic pops. It also reports framing and overrun errors as sticky flags.

---
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver, 16x oversampled, with a FWFT byte FIFO and
//             sticky framing/overrun flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_bit,
    input  logic [DIV_WIDTH-1:0]          div,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_STOP       = 3'd3,
        S_BREAK_WAIT = 3'd4
    } state_t;

    logic                 sync1_q, rx_s_q;
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic                 w_tick;

    state_t               state_q, state_d;
    logic [3:0]           os_q, os_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 w_push_req, w_frame_set;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]          w_count;
    logic                 w_empty, w_full, w_pop, w_push, w_ovr_set;
    logic                 frame_err_q, overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_bit;
            rx_s_q  <= sync1_q;
        end
    end

    // >= rather than == so that lowering div mid-count cannot strand the counter
    assign w_tick = (div_cnt_q >= div);

    always_ff @(posedge clk) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= w_tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            os_q      <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            os_q      <= os_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        os_d        = os_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        w_push_req  = 1'b0;
        w_frame_set = 1'b0;
        if (w_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        os_d    = 4'd0;
                    end
                end
                S_START: begin
                    if (os_q == 4'd7) begin
                        os_d      = 4'd0;
                        bit_idx_d = 3'd0;
                        state_d   = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (os_q == 4'd15) begin
                        shift_d[bit_idx_q] = rx_s_q;
                        os_d               = 4'd0;
                        if (bit_idx_q == 3'd7) state_d   = S_STOP;
                        else                   bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
                S_STOP: begin
                    if (os_q == 4'd15) begin
                        os_d = 4'd0;
                        if (rx_s_q) begin
                            w_push_req = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            w_frame_set = 1'b1;
                            state_d     = S_BREAK_WAIT;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
                S_BREAK_WAIT: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pointers carry one extra bit so full and empty are distinguishable
    assign w_count   = wr_ptr_q - rd_ptr_q;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == FULL_CNT);
    assign w_pop     = rd_en & ~w_empty;
    assign w_push    = w_push_req & (~w_full | w_pop);
    assign w_ovr_set = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            frame_err_q <= w_frame_set | (frame_err_q & ~err_clr);
            overrun_q   <= w_ovr_set   | (overrun_q   & ~err_clr);
        end
    end

    assign rd_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = w_count;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_bit;
    logic [7:0] div;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [2:0] count;
    logic       frame_err, overrun;
    logic       err_clr;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    uart_rx #(.FIFO_DEPTH(4), .DIV_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_bit    (rx_bit),
        .div       (div),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Returns 1 ns after the n-th rising edge, away from the active edge
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb);
        rx_bit = 1'b0;
        wait_clk(cpb);
        for (int i = 0; i < 8; i++) begin
            rx_bit = d[i];
            wait_clk(cpb);
        end
        rx_bit = stop;
        wait_clk(cpb);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        wait_clk(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rx_bit  = 1'b1;
        div     = 8'd1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        wait_clk(3);

        chk("rst_empty",     empty,     1);
        chk("rst_full",      full,      0);
        chk("rst_count",     count,     0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun",   overrun,   0);
        chk("rst_busy",      busy,      0);
        reset = 1'b0;
        wait_clk(4);

        // basic receive, 32 clk per bit
        send_frame(8'hA5, 1'b1, 32);
        wait_clk(4);
        chk("basic_empty",     empty,     0);
        chk("basic_data",      rd_data,   8'hA5);
        chk("basic_count",     count,     1);
        chk("basic_frame_err", frame_err, 0);
        pop();
        chk("basic_pop_empty", empty,     1);
        chk("basic_pop_count", count,     0);

        // glitch: 6 clk low
        rx_bit = 1'b0;
        wait_clk(5);
        chk("glitch_busy_mid", busy, 1);
        wait_clk(1);
        rx_bit = 1'b1;
        wait_clk(30);
        chk("glitch_busy",      busy,      0);
        chk("glitch_empty",     empty,     1);
        chk("glitch_frame_err", frame_err, 0);
        chk("glitch_overrun",   overrun,   0);

        // framing error, line held low afterwards
        send_frame(8'h3C, 1'b0, 32);
        wait_clk(200);
        chk("fe_flag",  frame_err, 1);
        chk("fe_empty", empty,     1);
        chk("fe_busy",  busy,      1);
        rx_bit = 1'b1;
        wait_clk(8);
        chk("fe_busy_released", busy, 0);
        send_frame(8'h55, 1'b1, 32);
        wait_clk(4);
        chk("fe_next_data",   rd_data,   8'h55);
        chk("fe_next_count",  count,     1);
        chk("fe_sticky",      frame_err, 1);
        pop();
        clear_errs();
        chk("fe_cleared", frame_err, 0);

        // overrun at div=0 (16 clk per bit)
        div = 8'd0;
        wait_clk(4);
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 1'b1, 16);
            wait_clk(4);
        end
        chk("ovr_full",    full,    1);
        chk("ovr_count",   count,   4);
        chk("ovr_flag",    overrun, 1);
        for (int v = 1; v <= 4; v++) begin
            chk($sformatf("ovr_pop%0d", v), rd_data, v);
            pop();
        end
        chk("ovr_drained", empty, 1);
        clear_errs();
        chk("ovr_cleared", overrun, 0);

        // full FIFO with a pop in the same cycle as the stop-sample push
        for (int v = 1; v <= 4; v++) begin
            send_frame(8'(v), 1'b1, 16);
            wait_clk(4);
        end
        chk("fp_prefull", full, 1);
        rx_bit = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 8; i++) begin
            rx_bit = (i == 0 || i == 2) ? 1'b1 : 1'b0;
            wait_clk(16);
        end
        rx_bit = 1'b1;
        // start driven just after edge k; stop sample lands on edge k+155
        wait_clk(10);
        rd_en = 1'b1;
        wait_clk(1);
        rd_en = 1'b0;
        wait_clk(9);
        chk("fp_overrun", overrun, 0);
        chk("fp_count",   count,   4);
        chk("fp_full",    full,    1);
        for (int v = 2; v <= 5; v++) begin
            chk($sformatf("fp_pop%0d", v), rd_data, v);
            pop();
        end
        chk("fp_drained", empty, 1);

        // reset during data bit 3 of 0xFF
        div = 8'd1;
        wait_clk(4);
        rx_bit = 1'b0;
        wait_clk(32);
        rx_bit = 1'b1;
        wait_clk(96 + 16);
        reset = 1'b1;
        wait_clk(1);
        chk("rm_busy",  busy,  0);
        chk("rm_empty", empty, 1);
        reset = 1'b0;
        wait_clk(4);
        send_frame(8'h81, 1'b1, 32);
        wait_clk(4);
        chk("rm_next_data",  rd_data,   8'h81);
        chk("rm_next_count", count,     1);
        chk("rm_frame_err",  frame_err, 0);
        pop();
        chk("rm_drained", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
